// File: rtl/dma_write_master.sv
// dma_write_master
//   Write-side stage of a simple DMA controller. Pops 32-bit words from the
//   shared data FIFO (normal, non-show-ahead mode) and writes them to an
//   Avalon-MM slave, starting at a word-aligned destination address, until
//   Length bytes have been written. The last word carries a partial,
//   little-endian byte enable when Length is not a multiple of 4.
//
// Ports
//   iClk, iReset        clock and synchronous active-high reset
//   Start, Length       transfer request (sampled only in IDLE) and byte count
//   WM_startaddress     destination byte address, low two bits ignored
//   FF_empty, FF_q      FIFO status and read data (valid the cycle after a pop)
//   FF_readrequest      FIFO pop, combinational
//   oWM_*               registered Avalon-MM write request/address/data/byteenable
//   iWM_waitrequest     slave stall
//   Busy, Done          activity level and one-cycle completion pulse
module dma_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  Start,
  input  logic [LEN_WIDTH-1:0]  Length,
  input  logic [ADDR_WIDTH-1:0] WM_startaddress,
  input  logic                  FF_empty,
  input  logic [31:0]           FF_q,
  output logic                  FF_readrequest,
  output logic                  oWM_write,
  output logic [ADDR_WIDTH-1:0] oWM_writeaddress,
  output logic [31:0]           oWM_writedata,
  output logic [3:0]            oWM_byteenable,
  input  logic                  iWM_waitrequest,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Byte enables for the word about to be written: full word while at least
  // four bytes remain, otherwise only the lowest 'remaining' bytes.
  logic [3:0] be_from_remaining;
  always_comb begin
    be_from_remaining = 4'b1111;
    if (remaining_q < LEN_WIDTH'(4)) begin
      case (remaining_q[1:0])
        2'd3:    be_from_remaining = 4'b0111;
        2'd2:    be_from_remaining = 4'b0011;
        2'd1:    be_from_remaining = 4'b0001;
        default: be_from_remaining = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    write_d        = write_q;
    waddr_d        = waddr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    busy_d         = busy_q;
    done_d         = done_q;
    FF_readrequest = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Done from the previous transfer drops here; Busy drops with it
        // unless a new transfer is accepted on this very edge.
        done_d = 1'b0;
        busy_d = 1'b0;
        if (Start) begin
          busy_d = 1'b1;
          if (Length != '0) begin
            addr_d      = WM_startaddress & ~ADDR_WIDTH'(3);
            remaining_d = Length;
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        if (!FF_empty) begin
          FF_readrequest = 1'b1;
          state_d        = S_LATCH;
        end
      end

      S_LATCH: begin
        // FF_q is valid now, one cycle after the pop issued in FETCH.
        wdata_d = FF_q;
        waddr_d = addr_q;
        be_d    = be_from_remaining;
        write_d = 1'b1;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (!iWM_waitrequest) begin
          write_d = 1'b0;
          addr_d  = addr_q + ADDR_WIDTH'(4);
          if (remaining_q <= LEN_WIDTH'(4)) begin
            remaining_d = '0;
            state_d     = S_DONE;
          end else begin
            remaining_d = remaining_q - LEN_WIDTH'(4);
            state_d     = S_FETCH;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign oWM_write        = write_q;
  assign oWM_writeaddress = waddr_q;
  assign oWM_writedata    = wdata_q;
  assign oWM_byteenable   = be_q;
  assign Busy             = busy_q;
  assign Done             = done_q;

endmodule

// File: tb/tb_dma_write_master.sv
// Self-checking bench for dma_write_master: a queue-based FIFO model, a
// slave model with programmable or random waitrequest, a negedge monitor,
// and a reference that lists the expected writes from the transfer rules.
module tb_dma_write_master;
  localparam int AW = 32;
  localparam int LW = 32;

  logic          iClk = 1'b0;
  logic          iReset = 1'b1;
  logic          Start = 1'b0;
  logic [LW-1:0] Length = '0;
  logic [AW-1:0] WM_startaddress = '0;
  logic          FF_empty;
  logic [31:0]   FF_q = '0;
  logic          FF_readrequest;
  logic          oWM_write;
  logic [AW-1:0] oWM_writeaddress;
  logic [31:0]   oWM_writedata;
  logic [3:0]    oWM_byteenable;
  logic          iWM_waitrequest = 1'b0;
  logic          Busy;
  logic          Done;

  always #5 iClk = ~iClk;

  dma_write_master #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .iClk(iClk), .iReset(iReset), .Start(Start), .Length(Length),
    .WM_startaddress(WM_startaddress), .FF_empty(FF_empty), .FF_q(FF_q),
    .FF_readrequest(FF_readrequest), .oWM_write(oWM_write),
    .oWM_writeaddress(oWM_writeaddress), .oWM_writedata(oWM_writedata),
    .oWM_byteenable(oWM_byteenable), .iWM_waitrequest(iWM_waitrequest),
    .Busy(Busy), .Done(Done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: pushes come from the stimulus, pops from the DUT request.
  logic [31:0] fifo_q[$];
  int push_total = 0;
  int pop_total  = 0;
  assign FF_empty = (push_total == pop_total);
  always @(posedge iClk) begin
    if (FF_readrequest && fifo_q.size() > 0) begin
      FF_q      <= fifo_q.pop_front();
      pop_total <= pop_total + 1;
    end
  end

  // Slave model and cycle counter. stall_left counts cycles the slave still
  // has to stall an asserted write.
  int cyc = 0;
  int stall_left = 0;
  bit rand_wait = 1'b0;
  always @(posedge iClk) begin
    cyc = cyc + 1;
    if (oWM_write && iWM_waitrequest && stall_left > 0) stall_left = stall_left - 1;
    if (rand_wait) iWM_waitrequest <= ($urandom_range(0, 2) == 0);
    else           iWM_waitrequest <= (stall_left > 0);
  end

  // Monitor
  logic [31:0] got_a[$], got_d[$];
  logic [3:0]  got_be[$];
  int done_cyc[$], rise_cyc[$];
  int pops = 0, dones = 0, underflows = 0, unstable = 0;
  logic        prev_stall = 1'b0, prev_write = 1'b0;
  logic [31:0] prev_a = '0, prev_d = '0;
  logic [3:0]  prev_be = '0;
  always @(negedge iClk) begin
    if (!iReset) begin
      if (oWM_write && !iWM_waitrequest) begin
        got_a.push_back(oWM_writeaddress);
        got_d.push_back(oWM_writedata);
        got_be.push_back(oWM_byteenable);
      end
      if (FF_readrequest) pops = pops + 1;
      if (FF_readrequest && FF_empty) underflows = underflows + 1;
      if (Done) begin
        dones = dones + 1;
        done_cyc.push_back(cyc);
      end
      if (oWM_write && !prev_write) rise_cyc.push_back(cyc);
      if (prev_stall && (!oWM_write || oWM_writeaddress !== prev_a ||
                         oWM_writedata !== prev_d || oWM_byteenable !== prev_be))
        unstable = unstable + 1;
    end
    prev_stall = !iReset && oWM_write && iWM_waitrequest;
    prev_write = oWM_write;
    prev_a     = oWM_writeaddress;
    prev_d     = oWM_writedata;
    prev_be    = oWM_byteenable;
  end

  // Reference: words sent into the FIFO and the writes they must produce.
  logic [31:0] sent_d[$];
  logic [31:0] exp_a[$], exp_d[$];
  logic [3:0]  exp_be[$];

  task automatic clear_mon();
    got_a.delete(); got_d.delete(); got_be.delete();
    done_cyc.delete(); rise_cyc.delete();
    exp_a.delete(); exp_d.delete(); exp_be.delete();
    pops = 0; dones = 0; underflows = 0; unstable = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    push_total = push_total + 1;
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    push_total = pop_total;
  endtask

  // Word i of a transfer goes to base+4i and carries min(4, len-4i) bytes.
  task automatic model_xfer(input logic [31:0] sa, input int len, input int first);
    logic [31:0] base;
    int nw, rem;
    base = sa - (sa % 4);
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      rem = len - 4 * i;
      exp_a.push_back(base + 32'(4 * i));
      exp_d.push_back(sent_d[first + i]);
      exp_be.push_back(rem >= 4 ? 4'hF : 4'((1 << rem) - 1));
    end
  endtask

  task automatic recover();
    iReset = 1'b1; Start = 1'b0;
    repeat (2) @(posedge iClk);
    #1 iReset = 1'b0;
    flush_fifo();
    stall_left = 0; rand_wait = 1'b0;
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    n_checks++; if (oWM_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", oWM_write); end
    n_checks++; if (oWM_writeaddress !== '0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", oWM_writeaddress); end
    n_checks++; if (oWM_writedata !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", oWM_writedata); end
    n_checks++; if (oWM_byteenable !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %h expected 0", oWM_byteenable); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done); end
    n_checks++; if (FF_readrequest !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b expected 0", FF_readrequest); end
    iReset = 1'b0;
    @(posedge iClk); #1;
    $display("test_reset: outputs at reset values checked");
  endtask

  // One complete transfer. Latency is counted with the Start-sampling edge
  // as edge 1: Done appears after edge 2 (Length=0) and the first write
  // after edge 3.
  task automatic test_transfer(input logic [31:0] sa, input int len, input bit slow,
                               input int stall, input bit rnd_wait,
                               input logic [31:0] pat, input string tag);
    int nw, pushed, n, start_edge;
    clear_mon();
    sent_d.delete();
    nw = (len + 3) / 4;
    for (int i = 0; i < nw; i++) sent_d.push_back(pat != 0 ? pat + 32'(i) : $urandom);
    stall_left = stall;
    rand_wait  = rnd_wait;
    pushed = 0;
    if (!slow) begin
      for (int i = 0; i < nw; i++) push_word(sent_d[i]);
      pushed = nw;
    end
    Start = 1'b1; Length = LW'(len); WM_startaddress = sa;
    start_edge = cyc + 1;
    @(posedge iClk); #1;
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b expected 1", tag, Busy); end
    n = 0;
    while (dones == 0 && n < 4000) begin
      if (slow && n >= 10 && (n - 10) % 4 == 0 && pushed < nw) begin
        push_word(sent_d[pushed]);
        pushed++;
      end
      @(posedge iClk); #1;
      n++;
    end
    if (dones == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s done_timeout: got no Done expected Done within 4000 cycles", tag);
      recover();
      return;
    end
    repeat (2) @(posedge iClk);
    #1;
    rand_wait = 1'b0; stall_left = 0;
    model_xfer(sa, len, 0);
    n_checks++; if (got_a.size() != exp_a.size()) begin n_fail++; $display("FAIL %s write_count: got %0d expected %0d", tag, got_a.size(), exp_a.size()); end
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
      n_checks++;
      if ({got_a[i], got_d[i], got_be[i]} !== {exp_a[i], exp_d[i], exp_be[i]}) begin
        n_fail++;
        $display("FAIL %s write%0d: got a=%h d=%h be=%h expected a=%h d=%h be=%h",
                 tag, i, got_a[i], got_d[i], got_be[i], exp_a[i], exp_d[i], exp_be[i]);
      end
    end
    n_checks++; if (pops != nw) begin n_fail++; $display("FAIL %s pop_count: got %0d expected %0d", tag, pops, nw); end
    n_checks++; if (dones != 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, dones); end
    n_checks++; if (underflows != 0) begin n_fail++; $display("FAIL %s pop_while_empty: got %0d expected 0", tag, underflows); end
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL %s held_during_wait: got %0d changes expected 0", tag, unstable); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after_done: got %b expected 0", tag, Busy); end
    if (len == 0) begin
      n_checks++; if (done_cyc[0] != start_edge + 1) begin n_fail++; $display("FAIL %s done_latency: got edge %0d expected %0d", tag, done_cyc[0], start_edge + 1); end
    end
    if (!slow && nw > 0 && rise_cyc.size() > 0) begin
      n_checks++; if (rise_cyc[0] != start_edge + 2) begin n_fail++; $display("FAIL %s first_write_latency: got edge %0d expected %0d", tag, rise_cyc[0], start_edge + 2); end
    end
    if (!slow && !rnd_wait && nw >= 2 && rise_cyc.size() >= 2) begin
      n_checks++; if (rise_cyc[1] - rise_cyc[0] != 3 + stall) begin n_fail++; $display("FAIL %s word_spacing: got %0d expected %0d", tag, rise_cyc[1] - rise_cyc[0], 3 + stall); end
    end
    $display("%s: addr=%h len=%0d writes=%0d pops=%0d dones=%0d", tag, sa, len, got_a.size(), pops, dones);
  endtask

  task automatic test_reset_mid();
    int n;
    bit hit;
    clear_mon();
    sent_d.delete();
    for (int i = 0; i < 4; i++) begin
      sent_d.push_back($urandom);
      push_word(sent_d[i]);
    end
    stall_left = 0;
    Start = 1'b1; Length = LW'(16); WM_startaddress = 32'h0000_6000;
    @(posedge iClk); #1;
    Start = 1'b0;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 200) begin
      if (got_a.size() == 1 && stall_left == 0) stall_left = 100;
      if (got_a.size() == 1 && oWM_write && iWM_waitrequest) hit = 1'b1;
      else begin
        @(posedge iClk); #1;
        n++;
      end
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL reset_mid_reach: got no second write expected one within 200 cycles");
      recover();
      return;
    end
    iReset = 1'b1;
    @(posedge iClk); #1;
    n_checks++; if (oWM_write !== 1'b0) begin n_fail++; $display("FAIL reset_mid_write: got %b expected 0", oWM_write); end
    n_checks++; if ({oWM_writeaddress, oWM_writedata, oWM_byteenable} !== '0) begin n_fail++; $display("FAIL reset_mid_outputs: got a=%h d=%h be=%h expected zeros", oWM_writeaddress, oWM_writedata, oWM_byteenable); end
    n_checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_status: got busy=%b done=%b expected 0 0", Busy, Done); end
    iReset = 1'b0;
    stall_left = 0;
    flush_fifo();
    repeat (3) @(posedge iClk);
    #1;
    n_checks++; if (got_a.size() != 1 || dones != 0) begin n_fail++; $display("FAIL reset_mid_dropped: got writes=%0d dones=%0d expected 1 0", got_a.size(), dones); end
    $display("test_reset_mid: reset during second write, writes=%0d dones=%0d", got_a.size(), dones);
    test_transfer(32'h0000_3000, 4, 1'b0, 0, 1'b0, 32'h0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    clear_mon();
    sent_d.delete();
    for (int i = 0; i < 3; i++) begin
      sent_d.push_back($urandom);
      push_word(sent_d[i]);
    end
    stall_left = 0;
    Start = 1'b1; Length = LW'(8); WM_startaddress = 32'h0000_4000;
    @(posedge iClk); #1;
    // Start stays high: ignored while busy, taken again the cycle after DONE.
    Length = LW'(3); WM_startaddress = 32'h0000_5002;
    n = 0;
    while (dones < 1 && n < 500) begin @(posedge iClk); #1; n++; end
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_kept: got %b expected 1", Busy); end
    n = 0;
    while (dones < 2 && n < 500) begin @(posedge iClk); #1; n++; end
    repeat (2) @(posedge iClk);
    #1;
    model_xfer(32'h0000_4000, 8, 0);
    model_xfer(32'h0000_5002, 3, 2);
    n_checks++; if (got_a.size() != 3) begin n_fail++; $display("FAIL b2b_write_count: got %0d expected 3", got_a.size()); end
    for (int i = 0; i < got_a.size() && i < 3; i++) begin
      n_checks++;
      if ({got_a[i], got_d[i], got_be[i]} !== {exp_a[i], exp_d[i], exp_be[i]}) begin
        n_fail++;
        $display("FAIL b2b_write%0d: got a=%h d=%h be=%h expected a=%h d=%h be=%h",
                 i, got_a[i], got_d[i], got_be[i], exp_a[i], exp_d[i], exp_be[i]);
      end
    end
    n_checks++; if (dones != 2 || pops != 3) begin n_fail++; $display("FAIL b2b_counts: got dones=%0d pops=%0d expected 2 3", dones, pops); end
    if (done_cyc.size() >= 1 && rise_cyc.size() >= 3) begin
      n_checks++; if (rise_cyc[2] != done_cyc[0] + 3) begin n_fail++; $display("FAIL b2b_restart: got edge %0d expected %0d", rise_cyc[2], done_cyc[0] + 3); end
    end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", Busy); end
    $display("test_back_to_back: writes=%0d dones=%0d pops=%0d", got_a.size(), dones, pops);
  endtask

  task automatic test_random();
    logic [31:0] sa;
    int len;
    bit slow, rw;
    for (int k = 0; k < 20; k++) begin
      sa   = $urandom;
      len  = $urandom_range(0, 37);
      slow = ($urandom_range(0, 3) == 0);
      rw   = $urandom_range(0, 1) == 1;
      test_transfer(sa, len, slow, 0, rw, 32'h0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_transfer(32'h0000_1000, 16, 1'b0, 0, 1'b0, 32'h0000_00A0, "basic_len16");
    test_transfer(32'h0000_2003, 7, 1'b0, 0, 1'b0, 32'h0, "partial_len7");
    test_transfer(32'h0000_2100, 6, 1'b0, 0, 1'b0, 32'h0, "partial_len6");
    test_transfer(32'h0000_2200, 1, 1'b0, 0, 1'b0, 32'h0, "partial_len1");
    test_transfer(32'h0000_7000, 8, 1'b0, 5, 1'b0, 32'h0, "waitrequest");
    test_transfer(32'h0000_8000, 20, 1'b1, 0, 1'b0, 32'h0, "slow_fifo");
    test_transfer(32'h0000_9000, 0, 1'b0, 0, 1'b0, 32'h0, "zero_length");
    test_transfer(32'hFFFF_FFF9, 13, 1'b0, 0, 1'b0, 32'h0, "addr_wrap");
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_write_master.md
Name: dma_write_master

Overview:
- DMAC write-side stage, directly downstream of the read master and the shared data FIFO.
- Pops 32-bit words from the FIFO and writes them to an Avalon-MM slave, starting at a programmed destination address, until Length bytes are written.
- Drives a partial byte-enable on the final word when Length is not a multiple of 4.
- Reports Busy while active and pulses Done for one cycle at completion.

Parameters:
ADDR_WIDTH, 32, width of destination address and write address bus
LEN_WIDTH, 32, width of the byte-length input and internal remaining counter

Ports:
iClk  input  1  clock; all logic on rising edge
iReset  input  1  synchronous, active-high reset
Start  input  1  level/pulse; sampled only in IDLE
Length  input  LEN_WIDTH  transfer length in bytes
WM_startaddress  input  ADDR_WIDTH  destination byte address; bits [1:0] ignored, treated as 0
FF_empty  input  1  FIFO empty flag
FF_q  input  32  FIFO read data, valid one cycle after FF_readrequest (normal, non-show-ahead mode)
FF_readrequest  output  1  FIFO pop; combinational = (state==FETCH && !FF_empty)
oWM_write  output  1  Avalon write request (registered)
oWM_writeaddress  output  ADDR_WIDTH  Avalon word-aligned byte address (registered)
oWM_writedata  output  32  Avalon write data (registered)
oWM_byteenable  output  4  Avalon byte enables (registered)
iWM_waitrequest  input  1  slave stall; write accepted on a cycle with oWM_write=1 and iWM_waitrequest=0
Busy  output  1  high from the cycle after Start is accepted until DONE exits
Done  output  1  one-cycle completion pulse

Behaviour:
- Clock/reset: one clock, iClk. Reset is iReset, synchronous and active-high.
- Reset values: state=IDLE, oWM_write=0, oWM_writeaddress=0, oWM_writedata=0, oWM_byteenable=0, Busy=0, Done=0, remaining=0.
- Reset mid-operation: return to IDLE on the next edge; the in-flight write is dropped; no Done pulse.
- IDLE, Start=1, Length≠0: latch addr={WM_startaddress[ADDR_WIDTH-1:2],2'b00} and remaining=Length; Busy<=1; go to FETCH.
- IDLE, Start=1, Length=0: Busy<=1; go to DONE. No FIFO pop, no writes.
- IDLE, Start=0: stay. Start asserted in any other state is ignored.
- FETCH: while FF_empty=1, hold with FF_readrequest=0. When FF_empty=0, pop exactly one word and go to LATCH.
- LATCH: oWM_writedata<=FF_q, oWM_writeaddress<=addr, oWM_write<=1. Byte enables from remaining:
  - >=4: 1111
  - 3: 0111
  - 2: 0011
  - 1: 0001
  - Little-endian: lowest bytes valid.
- LATCH always goes to WRITE.
- WRITE: oWM_write, address, data and byteenable are held stable while iWM_waitrequest=1.
- WRITE, on accept (iWM_waitrequest=0):
  - oWM_write<=0.
  - addr<=addr+4, wrapping modulo 2^ADDR_WIDTH with no error.
  - remaining<=remaining-min(4,remaining).
  - If remaining<=4, go to DONE; else go to FETCH.
- DONE: Done<=1 for exactly one cycle; Busy<=0 on the same edge as Done deasserts; go to IDLE.
- Throughput: 3 cycles per word minimum (FETCH, LATCH, WRITE) with a non-empty FIFO and no waitrequest.
- Latency: first oWM_write is asserted 3 edges after the edge that samples Start, when the FIFO is non-empty.
- Pop count: exactly ceil(Length/4) FIFO pops and ceil(Length/4) accepted writes per transfer. Never pop when FF_empty=1 (FIFO underflow is impossible by construction).
- FF_empty toggling during LATCH/WRITE has no effect; it is only consulted in FETCH.
- Back-to-back transfers: Start may be accepted in IDLE on the cycle right after DONE.

Test Plan:
- Length=16, addr=0x1000, FIFO preloaded with 0xA0..0xA3, waitrequest=0 -> 4 writes to 0x1000/0x1004/0x1008/0x100C, data A0..A3, byteenable 1111, 4 pops, Done pulse 1 cycle, Busy low afterwards.
- Length=7, addr=0x2003 -> address forced to 0x2000; writes 0x2000 be=1111, 0x2004 be=0111; exactly 2 pops.
- Length=8, iWM_waitrequest held high for 5 cycles on the first write -> oWM_write/address/data stable for all 6 cycles; 2 writes total; no extra pop.
- FIFO empty for 10 cycles after Start, then one word pushed per 4 cycles -> FF_readrequest never high while FF_empty=1; writes match push order.
- Length=0 with Start -> no FF_readrequest, no oWM_write; Done exactly 2 edges after Start sampled.
- iReset=1 asserted during WRITE of word 2 of 4 -> next cycle all outputs at reset values; a new Start with Length=4 then completes normally.
